// File: rtl/passthrough_fifo.sv
// Elastic valid/ready FIFO: DEPTH x WIDTH register array, first-word fall-through.
// Latency: a word pushed on edge N is visible on out_data in cycle N+1.
// Backpressure: in_ready drops when full (registered state only); writes while full set overflow.
module passthrough_fifo #(
    parameter int  WIDTH = 6,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, wr_en;

    assign in_ready  = (count_q != CNT_W'(DEPTH)) & ~rst;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rp_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        wr_en      = push & ~flush;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_W'(1);
            if (pop)  rp_d = rp_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A fresh overflow event outranks a same-cycle clear.
        if (clr_overflow) overflow_d = 1'b0;
        if (in_valid & ~in_ready & ~rst) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp_q] <= in_data;
    end
endmodule

// File: doc/passthrough_fifo.md
Name: passthrough_fifo

Overview:
Parametrised, elastic successor to the 6-bit combinational passthrough: moves WIDTH-bit words from a producer to a consumer through a DEPTH-entry buffer under valid/ready handshakes. Decouples ALU operand/result paths (switch inputs → ALU → display) so either side can stall without losing data. Adds occupancy reporting, synchronous flush and a sticky overflow flag for attempted writes while full.

Parameters:
WIDTH, 6, data word width in bits (>=1)
DEPTH, 4, number of buffer entries; power of two, >=2
CNT_W, $clog2(DEPTH)+1, localparam (derived, not overridable); width of occupancy count

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of buffer contents; does not clear overflow
in_data  input  WIDTH  producer data
in_valid  input  1  producer has a word on in_data
in_ready  output  1  buffer can accept a word this cycle
out_data  output  WIDTH  head-of-buffer word
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data this cycle
count  output  CNT_W  current occupancy, 0..DEPTH
overflow  output  1  sticky: set when in_valid=1 while in_ready=0
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst=1 sampled on a rising edge: read/write pointers, count -> 0, overflow -> 0, out_valid -> 0, out_data -> 0. in_ready = 0 while rst is high; it is 1 in the first cycle after rst deasserts.
- Storage: DEPTH x WIDTH register array, write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH (natural binary wrap, DEPTH-1 -> 0).
- push = in_valid & in_ready; pop = out_valid & out_ready. Both evaluated on the same edge.
- in_ready = (count != DEPTH) & ~rst. Depends only on registered state; no combinational path from out_ready to in_ready (a full buffer does not accept on a same-cycle pop).
- out_valid = (count != 0); out_data = mem[rp] (first-word fall-through). out_data is 0 when count == 0.
- Latency: a word pushed into an empty buffer on edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1). No combinational in->out bypass.
- count update: push only: +1; pop only: -1; push and pop together: unchanged, both pointers advance. count never exceeds DEPTH or goes below 0.
- Ordering: strict FIFO; words exit in acceptance order, bit-exact.
- flush=1 on an edge: wp, rp, count -> 0; any same-cycle push/pop is discarded; mem contents are don't-care. rst has priority over flush.
- overflow: set on any edge where in_valid=1 and in_ready=0 (including while rst or flush is high? no: not while rst=1; yes while flush=1). clr_overflow=1 clears it; if the set condition and clr_overflow coincide, set wins.
- Producer contract: in_data/in_valid may change freely when in_ready=0; the block does not require the producer to hold them stable.
- Reset mid-transfer: words in flight are lost; no partial outputs after reset.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=6'h2A -> count=0, out_valid=0, out_data=0, overflow=0, in_ready=0; the cycle after release, in_ready=1.
- Single word: push 6'h15 with out_ready=0 -> next cycle out_valid=1, out_data=6'h15, count=1; assert out_ready -> next cycle out_valid=0, count=0.
- Fill and overflow: push 6'h01,6'h02,6'h03,6'h04 with out_ready=0 -> count=4, in_ready=0; hold in_valid=1 with 6'h05 -> overflow=1, 6'h05 never appears; drain -> 01,02,03,04 in order.
- Simultaneous push/pop with count=2 over 10 cycles, streaming 6'h10..6'h19 -> count stays 2, outputs in order, pointers wrap past DEPTH-1 without corruption.
- Flush with count=3 while pushing 6'h3F -> next cycle count=0, out_valid=0, in_ready=1; overflow unchanged; 6'h3F not stored.
- clr_overflow with overflow=1 and no new overflow -> 0 next cycle; clr_overflow coinciding with an overflow event -> overflow stays 1.
